// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache arbiter onto one RAM port.
// Registered grant keeps dcache blocks intact with a bounded icache wait.
module mem_arbiter #(
  parameter int unsigned DBURST = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic       err_q, err_d;

  logic       dreq;
  logic       acc;
  logic       idone;
  logic       ddone;
  logic [2:0] dcnt_inc;
  logic       burst_up;

  assign dreq     = dREN | dWEN;
  assign acc      = (ramstate == RS_ACCESS);
  assign idone    = (state_q == IGNT) & iREN & acc;
  assign ddone    = (state_q == DGNT) & dreq & acc;
  assign dcnt_inc = {1'b0, dcnt_q} + 3'd1;
  assign burst_up = (32'(dcnt_inc) >= DBURST);

  assign iwait = ~idone;
  assign dwait = ~ddone;
  assign iload = ramload;
  assign dload = ramload;
  assign ram_err = err_q;

  // Next grant, burst count and sticky error.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    if (state_q != IDLE && ramstate == RS_ERROR)
      err_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d = DGNT;
          dcnt_d  = 2'd0;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      DGNT: begin
        if (ddone && dcnt_q != 2'd3)
          dcnt_d = dcnt_q + 2'd1;
        if (!dreq)
          state_d = IDLE;
        else if (ddone && burst_up && iREN)
          state_d = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else if (idone && dreq) begin
          state_d = DGNT;
          dcnt_d  = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM drive follows the owner's live request signals.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    unique case (state_q)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      dcnt_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, fairness,
// drop, error and reset behaviour of mem_arbiter.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ram_err;

  int nchk;
  int nerr;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.DBURST(2)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .ram_err  (ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_all();
    @(negedge CLK);
    iREN = 0; dREN = 0; dWEN = 0;
    ramstate = FREE;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 0;
    iREN = 1; dREN = 1; dWEN = 0;
    iaddr = 32'h10; daddr = 32'h20;
    dstore = 32'h33;
    ramstate = ACCESS;
    ramload = 32'h1234_5678;
    #1;
    nchk++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      nerr++;
      $display("FAIL reset_en ren=%b wen=%b need 0 0", ramREN, ramWEN);
    end
    nchk++;
    if (iwait !== 1'b1 || dwait !== 1'b1) begin
      nerr++;
      $display("FAIL reset_wait i=%b d=%b need 1 1", iwait, dwait);
    end
    nchk++;
    if (ram_err !== 1'b0 || ramaddr !== 32'd0) begin
      nerr++;
      $display("FAIL reset_err err=%b addr=%h need 0 0", ram_err, ramaddr);
    end
    nchk++;
    if (iload !== 32'h1234_5678 || dload !== 32'h1234_5678) begin
      nerr++;
      $display("FAIL reset_load i=%h d=%h need 12345678", iload, dload);
    end
    @(negedge CLK);
    @(negedge CLK);
    iREN = 0; dREN = 0;
    ramstate = FREE;
    nRST = 1;
    @(negedge CLK);
  endtask

  task automatic test_single_fetch();
    @(negedge CLK);
    iREN = 1; iaddr = 32'h40;
    ramstate = FREE;
    #1;
    nchk++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      nerr++;
      $display("FAIL fetch_c0 ren=%b iwait=%b need 0 1", ramREN, iwait);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK);
      ramstate = BUSY;
      #1;
      nchk++;
      if (ramaddr !== 32'h40 || ramREN !== 1'b1 || iwait !== 1'b1) begin
        nerr++;
        $display("FAIL fetch_busy%0d addr=%h ren=%b iwait=%b need 40 1 1",
                 c, ramaddr, ramREN, iwait);
      end
    end
    @(negedge CLK);
    ramstate = ACCESS;
    ramload = 32'hDEAD_BEEF;
    #1;
    nchk++;
    if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF || dwait !== 1'b1) begin
      nerr++;
      $display("FAIL fetch_acc iwait=%b iload=%h dwait=%b need 0 deadbeef 1",
               iwait, iload, dwait);
    end
    @(negedge CLK);
    iREN = 0;
    ramstate = FREE;
    #1;
    nchk++;
    if (iwait !== 1'b1 || ramREN !== 1'b0) begin
      nerr++;
      $display("FAIL fetch_end iwait=%b ren=%b need 1 0", iwait, ramREN);
    end
    @(negedge CLK);
  endtask

  task automatic test_simultaneous();
    @(negedge CLK);
    iREN = 1; iaddr = 32'h80;
    dWEN = 1; daddr = 32'h100; dstore = 32'h11;
    ramstate = ACCESS;
    #1;
    nchk++;
    if (iwait !== 1'b1 || dwait !== 1'b1 || ramWEN !== 1'b0) begin
      nerr++;
      $display("FAIL sim_c0 iw=%b dw=%b wen=%b need 1 1 0", iwait, dwait, ramWEN);
    end
    @(negedge CLK);
    #1;
    nchk++;
    if (ramaddr !== 32'h100 || ramstore !== 32'h11 || ramWEN !== 1'b1 ||
        dwait !== 1'b0 || iwait !== 1'b1) begin
      nerr++;
      $display("FAIL sim_w0 addr=%h st=%h wen=%b dw=%b iw=%b need 100 11 1 0 1",
               ramaddr, ramstore, ramWEN, dwait, iwait);
    end
    @(negedge CLK);
    daddr = 32'h104; dstore = 32'h22;
    #1;
    nchk++;
    if (ramaddr !== 32'h104 || ramstore !== 32'h22 || ramWEN !== 1'b1 ||
        dwait !== 1'b0 || iwait !== 1'b1) begin
      nerr++;
      $display("FAIL sim_w1 addr=%h st=%h wen=%b dw=%b iw=%b need 104 22 1 0 1",
               ramaddr, ramstore, ramWEN, dwait, iwait);
    end
    @(negedge CLK);
    dWEN = 0;
    #1;
    nchk++;
    if (ramaddr !== 32'h80 || ramREN !== 1'b1 || ramWEN !== 1'b0 ||
        iwait !== 1'b0 || dwait !== 1'b1) begin
      nerr++;
      $display("FAIL sim_i addr=%h ren=%b wen=%b iw=%b dw=%b need 80 1 0 0 1",
               ramaddr, ramREN, ramWEN, iwait, dwait);
    end
    idle_all();
  endtask

  task automatic test_fairness();
    logic [8:0] pat;
    pat = 9'b100_100_100;
    @(negedge CLK);
    dREN = 1; daddr = 32'h200;
    iREN = 1; iaddr = 32'h300;
    ramstate = ACCESS;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      #1;
      nchk++;
      if (pat[k]) begin
        if (ramaddr !== 32'h300 || iwait !== 1'b0 || dwait !== 1'b1) begin
          nerr++;
          $display("FAIL fair_i%0d addr=%h iw=%b dw=%b need 300 0 1",
                   k, ramaddr, iwait, dwait);
        end
      end else begin
        if (ramaddr !== 32'h200 || dwait !== 1'b0 || iwait !== 1'b1) begin
          nerr++;
          $display("FAIL fair_d%0d addr=%h iw=%b dw=%b need 200 1 0",
                   k, ramaddr, iwait, dwait);
        end
      end
    end
    idle_all();
  endtask

  task automatic test_drop();
    @(negedge CLK);
    dWEN = 1; daddr = 32'h500; dstore = 32'h55;
    ramstate = BUSY;
    @(negedge CLK);
    #1;
    nchk++;
    if (ramWEN !== 1'b1 || dwait !== 1'b1) begin
      nerr++;
      $display("FAIL drop_grant wen=%b dw=%b need 1 1", ramWEN, dwait);
    end
    @(negedge CLK);
    dWEN = 0;
    #1;
    nchk++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1) begin
      nerr++;
      $display("FAIL drop_same wen=%b dw=%b need 0 1", ramWEN, dwait);
    end
    @(negedge CLK);
    dWEN = 1;
    ramstate = ACCESS;
    #1;
    nchk++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'd0) begin
      nerr++;
      $display("FAIL drop_idle wen=%b dw=%b addr=%h need 0 1 0",
               ramWEN, dwait, ramaddr);
    end
    idle_all();
  endtask

  task automatic test_error();
    @(negedge CLK);
    dREN = 1; daddr = 32'h600;
    ramstate = FREE;
    #1;
    nchk++;
    if (ram_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pre err=%b need 0", ram_err);
    end
    @(negedge CLK);
    ramstate = ERROR;
    #1;
    nchk++;
    if (dwait !== 1'b1 || ramREN !== 1'b1 || ram_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_cyc dw=%b ren=%b err=%b need 1 1 0",
               dwait, ramREN, ram_err);
    end
    @(negedge CLK);
    ramstate = ACCESS;
    ramload = 32'h0000_CAFE;
    #1;
    nchk++;
    if (ram_err !== 1'b1 || dwait !== 1'b0 || dload !== 32'h0000_CAFE ||
        ramaddr !== 32'h600) begin
      nerr++;
      $display("FAIL err_retry err=%b dw=%b dload=%h addr=%h need 1 0 cafe 600",
               ram_err, dwait, dload, ramaddr);
    end
    idle_all();
    #1;
    nchk++;
    if (ram_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_sticky err=%b need 1", ram_err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    dREN = 1; daddr = 32'h700;
    ramstate = ACCESS;
    @(negedge CLK);
    #1;
    nchk++;
    if (dwait !== 1'b0 || ramREN !== 1'b1) begin
      nerr++;
      $display("FAIL mid_pre dw=%b ren=%b need 0 1", dwait, ramREN);
    end
    #1;
    nRST = 0;
    #1;
    nchk++;
    if (dwait !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'd0 ||
        ram_err !== 1'b0) begin
      nerr++;
      $display("FAIL mid_rst dw=%b ren=%b addr=%h err=%b need 1 0 0 0",
               dwait, ramREN, ramaddr, ram_err);
    end
    @(negedge CLK);
    dREN = 0;
    ramstate = FREE;
    nRST = 1;
    @(negedge CLK);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    nRST = 1;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_fairness();
    test_drop();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
